// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: N drawing sources -> one registered frame-manager write port.
// Latency: 1 cycle from an accepted request (grant & src_req & write_awaited) to write_active.
// Backpressure: write_awaited=0 blocks every write; outputs hold and the granted source stalls.
//
// Ports:
//   clk, resetN            pixel clock, asynchronous active-low reset
//   frame                  one-cycle start-of-frame pulse (samples src_enable)
//   src_enable/req/done    per-source enable mask, pixel valid, end-of-frame level
//   src_color/x/y/transp   packed per-source pixel payloads (source i at slice i)
//   grant                  one-hot; the granted source may present and advance
//   write_awaited          frame manager can accept a write this cycle
//   write_*                registered write strobe, payload and source index
//   frame_done             one-cycle pulse at end of frame
//   overrun, overrun_cnt   sticky overrun flag and saturating overrun count
// MODE 0 = painter's order (one source at a time per frame), MODE 1 = round-robin per write.
// Optional feature: define FB_ARB_OVERRUN_CNT_EN to build the 8-bit saturating overrun counter;
// without it overrun_cnt is tied to zero.
module fb_write_arbiter #(
  parameter int NUM_SOURCES = 4,
  parameter int COLOR_DEPTH = 9,
  parameter int ADDR_W      = 32,
  parameter int MODE        = 0,
  parameter int SEL_W       = $clog2(NUM_SOURCES)
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             frame,
  input  logic [NUM_SOURCES-1:0]           src_enable,
  input  logic [NUM_SOURCES-1:0]           src_req,
  input  logic [NUM_SOURCES-1:0]           src_done,
  input  logic [NUM_SOURCES*COLOR_DEPTH-1:0] src_color,
  input  logic [NUM_SOURCES*ADDR_W-1:0]    src_x,
  input  logic [NUM_SOURCES*ADDR_W-1:0]    src_y,
  input  logic [NUM_SOURCES-1:0]           src_transparent,
  output logic [NUM_SOURCES-1:0]           grant,
  input  logic                             write_awaited,
  output logic                             write_active,
  output logic                             write_transparent,
  output logic [COLOR_DEPTH-1:0]           write_color_data,
  output logic [ADDR_W-1:0]                write_x_addr,
  output logic [ADDR_W-1:0]                write_y_addr,
  output logic [SEL_W-1:0]                 write_source_sel,
  output logic                             frame_done,
  output logic                             overrun,
  output logic [7:0]                       overrun_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, DONE = 2'd2} state_t;

  state_t                 state;
  logic [NUM_SOURCES-1:0] en_q;
  logic [SEL_W-1:0]       cur;
  logic [SEL_W-1:0]       ptr;

  logic                   first_vld;
  logic [SEL_W-1:0]       first_idx;
  logic                   next_vld;
  logic [SEL_W-1:0]       next_idx;
  logic                   rr_vld;
  logic [SEL_W-1:0]       rr_idx;
  int                     rr_best;
  int                     rr_dist;
  logic [SEL_W-1:0]       win_idx;
  logic                   fire;
  logic                   ovr_evt;

  logic [COLOR_DEPTH-1:0] mux_color;
  logic [ADDR_W-1:0]      mux_x;
  logic [ADDR_W-1:0]      mux_y;
  logic                   mux_transp;

  // Lowest enabled index of the incoming mask: first source of a new frame.
  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (src_enable[i]) begin
        first_vld = 1'b1;
        first_idx = SEL_W'(i);
      end
    end
  end

  // Lowest enabled index strictly above cur: the painter's-order successor.
  always_comb begin
    next_vld = 1'b0;
    next_idx = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (en_q[i] && (i > int'(cur))) begin
        next_vld = 1'b1;
        next_idx = SEL_W'(i);
      end
    end
  end

  // Round-robin: the candidate with the smallest cyclic distance from ptr wins.
  always_comb begin
    rr_vld  = 1'b0;
    rr_idx  = '0;
    rr_best = NUM_SOURCES;
    rr_dist = 0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      rr_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NUM_SOURCES - int'(ptr));
      if (src_req[i] && en_q[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_vld  = 1'b1;
        rr_idx  = SEL_W'(i);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (MODE == 0) begin
      if (state == SERVE) grant[cur] = 1'b1;
    end else if (write_awaited && rr_vld) begin
      grant[rr_idx] = 1'b1;
    end
  end

  assign win_idx = (MODE == 0) ? cur : rr_idx;
  assign fire    = (|(grant & src_req)) && write_awaited;
  // A frame arriving while a frame is still being painted (or just finishing).
  assign ovr_evt = frame && (state != IDLE);

  always_comb begin
    mux_color  = '0;
    mux_x      = '0;
    mux_y      = '0;
    mux_transp = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (win_idx == SEL_W'(i)) begin
        mux_color  = src_color[i*COLOR_DEPTH +: COLOR_DEPTH];
        mux_x      = src_x[i*ADDR_W +: ADDR_W];
        mux_y      = src_y[i*ADDR_W +: ADDR_W];
        mux_transp = src_transparent[i];
      end
    end
  end

  // Scheduler state. frame takes priority over src_done so an overrun always restarts cleanly.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      en_q       <= '0;
      cur        <= '0;
      ptr        <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (MODE == 0) begin
        if (frame) begin
          if (ovr_evt) overrun <= 1'b1;
          en_q <= src_enable;
          if (first_vld) begin
            cur   <= first_idx;
            state <= SERVE;
          end else begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end else begin
          case (state)
            SERVE: begin
              if (src_done[cur]) begin
                if (next_vld) begin
                  cur <= next_idx;
                end else begin
                  state      <= DONE;
                  frame_done <= 1'b1;
                end
              end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end else begin
        frame_done <= frame;
        if (frame) en_q <= src_enable;
        if (fire) ptr <= (rr_idx == SEL_W'(NUM_SOURCES - 1)) ? '0 : rr_idx + SEL_W'(1);
      end
    end
  end

  // Registered write bus; payload only changes on an accepted write.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      write_active      <= 1'b0;
      write_transparent <= 1'b0;
      write_color_data  <= '0;
      write_x_addr      <= '0;
      write_y_addr      <= '0;
      write_source_sel  <= '0;
    end else begin
      write_active <= fire;
      if (fire) begin
        write_transparent <= mux_transp;
        write_color_data  <= mux_color;
        write_x_addr      <= mux_x;
        write_y_addr      <= mux_y;
        write_source_sel  <= win_idx;
      end
    end
  end

`ifdef FB_ARB_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      overrun_cnt <= 8'd0;
    end else if (ovr_evt && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Parametrised frame-buffer write arbiter placed between N drawing units (background, starfield, calibration overlay, sprites) and the frame manager's single write port. It replaces hard-wired source-select sequencing with a per-frame painter's-order scheduler or a per-pixel round-robin scheduler, chosen by parameter. It adds an enable mask, overrun detection and a registered, glitch-free write bus.

## Interface
- NUM_SOURCES, 4: number of drawing sources, range 2..16.
- COLOR_DEPTH, 9: color word width.
- ADDR_W, 32: x/y address width.
- MODE, 0: selects the scheduler. 0 = painter's order (sequential per frame); 1 = round-robin per write.
- SEL_W, $clog2(NUM_SOURCES): derived; never overridden.

Ports:
- clk  in  1  pixel clock (clk_25 domain).
- resetN  in  1  asynchronous active-low reset.
- frame  in  1  one-cycle start-of-frame pulse.
- src_enable  in  NUM_SOURCES  per-source enable mask. Sampled on frame.
- src_req  in  NUM_SOURCES  source has a valid pixel.
- src_done  in  NUM_SOURCES  source finished its frame. Level; honoured in MODE 0 only.
- src_color  in  NUM_SOURCES*COLOR_DEPTH  packed; source i at [i*COLOR_DEPTH +: COLOR_DEPTH].
- src_x, src_y  in  NUM_SOURCES*ADDR_W  packed addresses.
- src_transparent  in  NUM_SOURCES  pixel is transparent.
- grant  out  NUM_SOURCES  one-hot; source may present and advance.
- write_awaited  in  1  frame manager ready to accept a write.
- write_active, write_transparent  out  1  registered write strobe / flag.
- write_color_data  out  COLOR_DEPTH; write_x_addr, write_y_addr  out  ADDR_W.
- write_source_sel  out  SEL_W  index of the source being written.
- frame_done  out  1  one-cycle pulse when all enabled sources are done (MODE 0).
- overrun  out  1  sticky; set when frame arrives before frame_done. Cleared by reset only.
- overrun_cnt  out  8  saturating overrun count (see Configuration).

## Operation
- MODE 0 FSM: IDLE -> SERVE -> DONE -> IDLE.
  - IDLE: on frame, latch src_enable into en_q, set cur to the lowest enabled index, go to SERVE. If no source is enabled, go straight to DONE.
  - SERVE: grant = onehot(cur). When src_done[cur]=1, cur advances to the next enabled index. Past the last enabled index, go to DONE.
  - DONE: pulse frame_done for 1 cycle, go to IDLE.
- MODE 1: no frame sequencing.
  - Each cycle with write_awaited=1, grant the first requesting enabled source at or after ptr, searching cyclically.
  - ptr becomes the winner + 1, wrapping mod NUM_SOURCES.
  - en_q still updates on frame.
  - frame_done pulses on every frame.
- A write fires in cycle t when the granted source has src_req=1 and write_awaited=1. In that case:
  - write_active=1 at t+1.
  - Data, address, transparent and write_source_sel are captured from the winner at t.
- When no write fires, write_active=0 and the data outputs hold their last values.
- frame while in SERVE or DONE (MODE 0):
  - Set overrun.
  - Abort the current source and restart at IDLE->SERVE with a fresh en_q in the same cycle.
  - No frame_done pulse for the aborted frame.
- Disabled sources never receive grant, even if they request.

## Timing
- Reset values: grant=0, write_active=0, write_transparent=0, write_color_data=0, write_x_addr=0, write_y_addr=0, write_source_sel=0, frame_done=0, overrun=0, overrun_cnt=0, state=IDLE, ptr=0, en_q=0.
- grant is combinational from registered state (cur/ptr, en_q). In MODE 1 it also depends on src_req and write_awaited.
- Latency: 1 cycle from accepted request to write_active. Sustained throughput is 1 write/cycle.
- src_done and frame in the same cycle: frame wins (overrun path).
- src_done[cur] and an accepted write in the same cycle: the write is issued and cur advances.
- Source handover takes 0 idle cycles; the next source is granted in the cycle after src_done.
- Asynchronous reset mid-write: write_active drops immediately. The pending pixel is lost.

## Configuration
- FB_ARB_OVERRUN_CNT_EN defined: overrun_cnt increments on each overrun event and saturates at 255.
- Not defined: overrun_cnt is tied to 0 and no counter logic is synthesised. The sticky overrun flag is unaffected.

## Test plan
- MODE 0, N=3, all enabled. Each source issues 4 writes then src_done. Expect 12 writes with write_source_sel 0,0,0,0,1,…,2 and frame_done 1 cycle after source 2 is done.
- MODE 0, src_enable=3'b101. Expect source 1 never granted, sel sequence 0 then 2, and frame_done pulsed.
- MODE 1, all 4 sources requesting continuously, write_awaited=1. Expect sel 0,1,2,3,0,… with write_active high every cycle after the first.
- write_awaited=0 for 5 cycles mid-stream. Expect write_active=0 and outputs held, then resume with no lost or duplicated pixel.
- MODE 0, frame pulsed while serving source 1. Expect overrun=1, overrun_cnt=1 (macro defined) or 0 (macro undefined), and a restart at source 0.
- resetN asserted mid-write. Expect all outputs 0 asynchronously; after release, IDLE until the next frame.
